fns_repair_ctrl: RTL

Sequences TSV fault scanning and repair configuration for the 9-TSV (8 signal + 1 redundant) FNS adder bank. Polls an external TSV test engine one TSV at a time over a req/ack handshake and assembles the fault vector that drives the adder bank's f_flag input. After the adder chain settles, it latches the bank's en_flag and redundant flag into stable configuration registers. Sits between the BIST/test engine and the TSV mux configuration, so downstream muxes never see the adder bank's combinational churn during a scan.

---
 rtl/fns_ctrl_pkg.sv | 25 ++
 rtl/fns_repair_ctrl_if.sv | 25 ++
 rtl/fns_ack_timer.sv | 29 ++
 rtl/fns_repair_ctrl.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/fns_ctrl_pkg.sv
// Shared types and sizing for the FNS TSV repair controller.
// State encoding, default geometry and saturating counter helper.
package fns_ctrl_pkg;

    localparam int N_TSV_DEF = 9;
    localparam int N_RED_DEF = 1;
    localparam int IDX_W     = 4;
    localparam int CNT_W     = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SCAN,
        ST_GAP,
        ST_SETTLE,
        ST_COMMIT
    } state_t;

    function automatic logic [CNT_W-1:0] sat_inc(
        input logic [CNT_W-1:0] c,
        input logic             inc
    );
        return (inc && c != '1) ? c + 1'b1 : c;
    endfunction

endpackage

// File: rtl/fns_repair_ctrl_if.sv
// Request/acknowledge link between the repair controller and the
// external TSV test engine.
interface fns_repair_ctrl_if;
    import fns_ctrl_pkg::*;

    logic             test_req;
    logic [IDX_W-1:0] test_sel;
    logic             test_ack;
    logic             test_fail;

    modport master (
        output test_req,
        output test_sel,
        input  test_ack,
        input  test_fail
    );

    modport slave (
        input  test_req,
        input  test_sel,
        output test_ack,
        output test_fail
    );

endinterface

// File: rtl/fns_ack_timer.sv
// Loadable down-counter bounding how long a test request may wait.
// expired is high once TIMEOUT enabled cycles have elapsed since load.
module fns_ack_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic expired
);

    localparam logic [7:0] LOAD_VAL = 8'(TIMEOUT - 1);

    logic [7:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= LOAD_VAL;
        end else if (en && cnt != '0) begin
            cnt <= cnt - 8'd1;
        end
    end

    assign expired = (cnt == '0);

endmodule

// File: rtl/fns_repair_ctrl.sv
// Scans TSVs through the test engine, builds the FNS fault vector and
// commits the settled enable/redundant flags into stable registers.
module fns_repair_ctrl
    import fns_ctrl_pkg::*;
#(
    parameter int N_TSV       = N_TSV_DEF,
    parameter int N_RED       = N_RED_DEF,
    parameter int SETTLE_CYC  = 1,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    fns_repair_ctrl_if.master    tst,
    output logic [N_TSV-1:0]     fns_f_flag,
    input  logic [N_TSV-1:0]     fns_en_flag,
    input  logic                 fns_r_flag,
    output logic [N_TSV-1:0]     en_flag_q,
    output logic                 r_flag_q,
    output logic                 cfg_valid,
    output logic                 repair_fail,
    output logic                 timeout_err,
    output logic [CNT_W-1:0]     fault_cnt,
    output logic                 busy,
    output logic                 done
);

    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(N_TSV - 1);
    localparam logic [CNT_W-1:0] RED_MAX     = CNT_W'(N_RED);
    localparam logic [2:0]       SETTLE_LAST = 3'(SETTLE_CYC - 1);

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [CNT_W-1:0] cnt;
    logic             to_flag;
    logic [2:0]       settle_cnt;
    logic             req_q;
    logic [IDX_W-1:0] sel_q;
    logic             tmr_load;
    logic             tmr_expired;

    // Timer restarts on every entry into SCAN.
    assign tmr_load = (state == ST_IDLE && start) ||
                      (state == ST_GAP && !abort && idx != LAST_IDX);

    fns_ack_timer #(
        .TIMEOUT (ACK_TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .load    (tmr_load),
        .en      (state == ST_SCAN),
        .expired (tmr_expired)
    );

    assign tst.test_req = req_q;
    assign tst.test_sel = sel_q;
    assign busy         = (state != ST_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            idx         <= '0;
            cnt         <= '0;
            to_flag     <= 1'b0;
            settle_cnt  <= '0;
            req_q       <= 1'b0;
            sel_q       <= '0;
            fns_f_flag  <= '0;
            en_flag_q   <= '0;
            r_flag_q    <= 1'b0;
            cfg_valid   <= 1'b0;
            repair_fail <= 1'b0;
            timeout_err <= 1'b0;
            fault_cnt   <= '0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort && state != ST_IDLE) begin
                state      <= ST_IDLE;
                req_q      <= 1'b0;
                fns_f_flag <= '0;
            end else begin
                unique case (state)
                    ST_IDLE: begin
                        if (start) begin
                            fns_f_flag <= '0;
                            cnt        <= '0;
                            to_flag    <= 1'b0;
                            idx        <= '0;
                            sel_q      <= '0;
                            req_q      <= 1'b1;
                            state      <= ST_SCAN;
                        end
                    end
                    ST_SCAN: begin
                        if (tst.test_ack) begin
                            fns_f_flag[idx] <= tst.test_fail;
                            cnt   <= sat_inc(cnt, tst.test_fail);
                            req_q <= 1'b0;
                            state <= ST_GAP;
                        end else if (tmr_expired) begin
                            // A silent TSV is treated as faulty.
                            fns_f_flag[idx] <= 1'b1;
                            cnt     <= sat_inc(cnt, 1'b1);
                            to_flag <= 1'b1;
                            req_q   <= 1'b0;
                            state   <= ST_GAP;
                        end
                    end
                    ST_GAP: begin
                        if (idx == LAST_IDX) begin
                            settle_cnt <= '0;
                            state      <= ST_SETTLE;
                        end else begin
                            idx   <= idx + 1'b1;
                            sel_q <= idx + 1'b1;
                            req_q <= 1'b1;
                            state <= ST_SCAN;
                        end
                    end
                    ST_SETTLE: begin
                        if (settle_cnt == SETTLE_LAST) begin
                            state <= ST_COMMIT;
                        end else begin
                            settle_cnt <= settle_cnt + 3'd1;
                        end
                    end
                    ST_COMMIT: begin
                        fault_cnt   <= cnt;
                        timeout_err <= to_flag;
                        cfg_valid   <= 1'b1;
                        done        <= 1'b1;
                        state       <= ST_IDLE;
                        if (cnt <= RED_MAX) begin
                            en_flag_q   <= fns_en_flag;
                            r_flag_q    <= fns_r_flag;
                            repair_fail <= 1'b0;
                        end else begin
                            en_flag_q   <= '0;
                            r_flag_q    <= 1'b0;
                            repair_fail <= 1'b1;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
